// File: rtl/bus_defs.sv
// Shared system-bus definitions: response codes, transfer direction and the
// memory slave's state encoding.
package bus_defs;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

endpackage

// File: rtl/slave_mem_array.sv
// DEPTH x DATA_W register array: synchronous write, registered read and
// synchronous clear on rst.
module slave_mem_array #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // A read issued in the same cycle as a write to that word sees the new data.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem_q[waddr] <= wdata;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave on the system bus with configurable wait states
// and a two-cycle ERROR response for unaligned or out-of-range accesses.
//
//   state | meaning
//   IDLE  | no transfer in progress, rdy=1, resp=OKAY
//   WAIT  | wait states of an OKAY transfer, rdy=0
//   DATA  | OKAY data phase, rdy=1; write commits at end of cycle
//   ERR1  | first ERROR cycle, rdy=0, resp=ERROR
//   ERR2  | second ERROR cycle, rdy=1, resp=ERROR
module bus_slave_mem
    import bus_defs::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              trans,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        resp,
    output logic              rdy
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [11:0] HI_MASK = 12'hFFF << (IDX_W + 2);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rw_q, rw_d;
    logic             rdy_q, rdy_d;
    resp_e            resp_q, resp_d;

    logic             accept;
    logic             addr_err;
    logic [IDX_W-1:0] addr_idx;
    logic             mem_we;
    logic             mem_re;
    logic [IDX_W-1:0] rd_idx;
    logic             unused_addr_hi;

    // Bits [15:12] belong to the external decoder.
    assign unused_addr_hi = ^address[ADDR_W-1:12];
    assign addr_idx       = address[IDX_W+1:2];
    assign addr_err       = (address[1:0] != 2'b00) || ((address[11:0] & HI_MASK) != 12'h000);
    assign accept         = sel && trans &&
                            ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        rd_idx  = idx_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                    mem_re  = (rw_q == RW_READ);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_DATA: begin
                mem_we  = (rw_q == RW_WRITE);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d = addr_idx;
            rw_d  = read_write;
            if (addr_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
                state_d = ST_DATA;
                mem_re  = (read_write == RW_READ);
                rd_idx  = addr_idx;
            end
        end

        rdy_d  = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        resp_d = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            rw_q    <= RW_READ;
            rdy_q   <= 1'b1;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            rdy_q   <= rdy_d;
            resp_q  <= resp_d;
        end
    end

    slave_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (mem_we),
        .waddr  (idx_q),
        .wdata  (wdata),
        .re     (mem_re),
        .raddr  (rd_idx),
        .rdata  (rdata)
    );

    assign rdy  = rdy_q;
    assign resp = resp_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: three instances with WAIT_STATES 1, 3 and 0,
// driven by a vector table, hand-written sequences and random transfers.
module tb_bus_slave_mem;

    localparam int DEPTH     = 16;
    localparam int WS_TAB[3] = '{1, 3, 0};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i   [3];
    logic        sel_i   [3];
    logic        trans_i [3];
    logic        rw_i    [3];
    logic [15:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [31:0] rdata_o [3];
    logic [1:0]  resp_o  [3];
    logic        rdy_o   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_slave_mem #(
            .ADDR_W      (16),
            .DATA_W      (32),
            .DEPTH       (DEPTH),
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst_i[g]),
            .sel         (sel_i[g]),
            .trans       (trans_i[g]),
            .read_write  (rw_i[g]),
            .address     (addr_i[g]),
            .wdata       (wdata_i[g]),
            .rdata       (rdata_o[g]),
            .resp        (resp_o[g]),
            .rdy         (rdy_o[g])
        );
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_m   [3][DEPTH];
    logic [31:0] last_rd [3];

    typedef struct {
        int          k;
        logic        rw;
        logic [15:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_bus(input int k, input string nm, input logic rdy_e, input logic [1:0] resp_e);
        chk($sformatf("d%0d %s rdy", k, nm), 32'(rdy_o[k]), 32'(rdy_e));
        chk($sformatf("d%0d %s resp", k, nm), 32'(resp_o[k]), 32'(resp_e));
        chk($sformatf("d%0d %s rdata", k, nm), rdata_o[k], last_rd[k]);
    endtask

    // One isolated transfer; the expected response sequence follows from the
    // wait-state count and the address rules.
    task automatic xfer(input int k, input logic rw, input logic [15:0] a, input logic [31:0] d,
                        input string nm, output logic [31:0] got);
        int lo;
        int idx;
        bit bad;
        lo  = int'(a) & 'hFFF;
        idx = lo / 4;
        bad = (lo % 4 != 0) || (idx >= DEPTH);
        @(negedge clk);
        sel_i[k] = 1'b1; trans_i[k] = 1'b1; rw_i[k] = rw; addr_i[k] = a; wdata_i[k] = d;
        @(posedge clk);
        #1;
        sel_i[k] = 1'b0; trans_i[k] = 1'b0; rw_i[k] = ~rw; addr_i[k] = ~a;
        if (bad) begin
            @(negedge clk); chk_bus(k, {nm, " err1"}, 1'b0, 2'b01);
            @(negedge clk); chk_bus(k, {nm, " err2"}, 1'b1, 2'b01);
            got = rdata_o[k];
        end else begin
            for (int i = 0; i < WS_TAB[k]; i++) begin
                @(negedge clk); chk_bus(k, {nm, " wait"}, 1'b0, 2'b00);
            end
            @(negedge clk);
            if (rw == 1'b0) last_rd[k] = mem_m[k][idx];
            chk_bus(k, {nm, " data"}, 1'b1, 2'b00);
            got = rdata_o[k];
            if (rw == 1'b1) mem_m[k][idx] = d;
        end
        @(negedge clk); chk_bus(k, {nm, " idle"}, 1'b1, 2'b00);
    endtask

    initial begin
        logic [31:0] got;
        for (int k = 0; k < 3; k++) begin
            rst_i[k] = 1'b1; sel_i[k] = 1'b0; trans_i[k] = 1'b0; rw_i[k] = 1'b0;
            addr_i[k] = '0; wdata_i[k] = '0; last_rd[k] = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
        end

        tab[0]  = '{0, 1'b0, 16'h2008, 32'd0,        1'b1, 32'd0};
        tab[1]  = '{0, 1'b1, 16'h2008, 32'd50,       1'b0, 32'd0};
        tab[2]  = '{0, 1'b0, 16'h2008, 32'd0,        1'b1, 32'd50};
        tab[3]  = '{0, 1'b1, 16'h2002, 32'd77,       1'b0, 32'd0};
        tab[4]  = '{0, 1'b1, 16'h2040, 32'd88,       1'b0, 32'd0};
        tab[5]  = '{0, 1'b0, 16'h2008, 32'd0,        1'b1, 32'd50};
        tab[6]  = '{0, 1'b0, 16'h2002, 32'd0,        1'b0, 32'd0};
        tab[7]  = '{0, 1'b1, 16'hF00C, 32'd7,        1'b0, 32'd0};
        tab[8]  = '{0, 1'b0, 16'h000C, 32'd0,        1'b1, 32'd7};
        tab[9]  = '{2, 1'b1, 16'h203C, 32'hDEAD,     1'b0, 32'd0};
        tab[10] = '{2, 1'b0, 16'h203C, 32'd0,        1'b1, 32'hDEAD};
        tab[11] = '{1, 1'b1, 16'h2008, 32'd11,       1'b0, 32'd0};
        tab[12] = '{1, 1'b0, 16'h2008, 32'd0,        1'b1, 32'd11};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_bus(k, "reset", 1'b1, 2'b00);
            rst_i[k] = 1'b0;
        end

        foreach (tab[i]) begin
            xfer(tab[i].k, tab[i].rw, tab[i].a, tab[i].d, $sformatf("tab%0d", i), got);
            if (tab[i].chk) chk($sformatf("tab%0d value", i), got, tab[i].exp);
        end

        // Back-to-back writes with trans held through the first data phase.
        @(negedge clk);
        sel_i[0] = 1'b1; trans_i[0] = 1'b1; rw_i[0] = 1'b1; addr_i[0] = 16'h2004; wdata_i[0] = 32'd567;
        @(negedge clk); chk_bus(0, "b2b w1 wait", 1'b0, 2'b00);
        @(negedge clk); chk_bus(0, "b2b w1 data", 1'b1, 2'b00);
        addr_i[0] = 16'h200C;
        @(negedge clk); chk_bus(0, "b2b w2 wait", 1'b0, 2'b00);
        wdata_i[0] = 32'd434; sel_i[0] = 1'b0; trans_i[0] = 1'b0;
        @(negedge clk); chk_bus(0, "b2b w2 data", 1'b1, 2'b00);
        @(negedge clk); chk_bus(0, "b2b idle", 1'b1, 2'b00);
        mem_m[0][1] = 32'd567;
        mem_m[0][3] = 32'd434;
        xfer(0, 1'b0, 16'h2004, 32'd0, "b2b rd1", got); chk("b2b rd1 value", got, 32'd567);
        xfer(0, 1'b0, 16'h200C, 32'd0, "b2b rd2", got); chk("b2b rd2 value", got, 32'd434);

        // Zero-wait write immediately followed by a read of the same word.
        @(negedge clk);
        sel_i[2] = 1'b1; trans_i[2] = 1'b1; rw_i[2] = 1'b1; addr_i[2] = 16'h2010; wdata_i[2] = 32'hABCD1234;
        @(negedge clk); chk_bus(2, "fwd wr", 1'b1, 2'b00);
        rw_i[2] = 1'b0;
        @(negedge clk);
        last_rd[2] = 32'hABCD1234;
        chk_bus(2, "fwd rd", 1'b1, 2'b00);
        sel_i[2] = 1'b0; trans_i[2] = 1'b0;
        mem_m[2][4] = 32'hABCD1234;
        @(negedge clk); chk_bus(2, "fwd idle", 1'b1, 2'b00);

        // Select gating: only sel and trans together start a transfer.
        @(negedge clk);
        sel_i[0] = 1'b0; trans_i[0] = 1'b1; rw_i[0] = 1'b1; addr_i[0] = 16'h2008; wdata_i[0] = 32'd123;
        repeat (2) begin @(negedge clk); chk_bus(0, "trans only", 1'b1, 2'b00); end
        sel_i[0] = 1'b1; trans_i[0] = 1'b0;
        repeat (2) begin @(negedge clk); chk_bus(0, "sel only", 1'b1, 2'b00); end
        sel_i[0] = 1'b0;
        xfer(0, 1'b0, 16'h2008, 32'd0, "gate rd", got); chk("gate rd value", got, 32'd50);

        // Reset during the second wait cycle of a WAIT_STATES=3 write.
        @(negedge clk);
        sel_i[1] = 1'b1; trans_i[1] = 1'b1; rw_i[1] = 1'b1; addr_i[1] = 16'h2008; wdata_i[1] = 32'd99;
        @(posedge clk);
        #1;
        sel_i[1] = 1'b0; trans_i[1] = 1'b0;
        @(negedge clk); chk_bus(1, "rst w1", 1'b0, 2'b00);
        @(negedge clk); chk_bus(1, "rst w2", 1'b0, 2'b00);
        rst_i[1] = 1'b1;
        @(negedge clk);
        last_rd[1] = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[1][i] = '0;
        chk_bus(1, "rst out", 1'b1, 2'b00);
        rst_i[1] = 1'b0;
        repeat (4) begin @(negedge clk); chk_bus(1, "rst after", 1'b1, 2'b00); end
        xfer(1, 1'b0, 16'h2008, 32'd0, "rst rd", got); chk("rst rd value", got, 32'd0);

        // Random transfers against the array model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                int          r;
                int          idx;
                int          lo;
                logic [15:0] a;
                r   = $urandom_range(0, 9);
                idx = $urandom_range(0, DEPTH - 1);
                if (r < 7)       lo = idx * 4;
                else if (r == 7) lo = idx * 4 + $urandom_range(1, 3);
                else             lo = $urandom_range(DEPTH, 1023) * 4;
                a = {4'($urandom_range(0, 15)), 12'(lo)};
                xfer(k, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", n), got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
